param_processor: RTL and testbench

- Parametrised successor to the team's 16-bit multicycle processor: single-clock, W-bit datapath, eight registers with R7 acting as the PC, and an ALU with flags.
- Adds a load/store memory port, a sign-extended relative conditional branch, an AND op and a debug register read port.
- Sits between a synchronous single-port memory (instructions and data share it) and board-level run/done control.

---
 rtl/param_processor.sv | 187 ++++++++++++++++++
 tb/tb_param_processor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_processor.sv
// param_processor: parametrised multicycle processor core.
// W-bit datapath, eight registers (R7 is the PC), ALU with {N,C,Z} flags,
// load/store through a shared synchronous single-port memory, and a
// combinational debug register read port.
module param_processor #(
  parameter int unsigned    W        = 16,
  parameter logic [W-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic [W-1:0] mem_rdata,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  output logic         mem_we,
  output logic         done,
  output logic [W-1:0] pc,
  output logic [2:0]   flags,
  input  logic [2:0]   dbg_sel,
  output logic [W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_LOADIR,
    S_EXEC,
    S_LDWAIT
  } state_t;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVT = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_LD  = 3'b100,
    OP_ST  = 3'b101,
    OP_AND = 3'b110,
    OP_B   = 3'b111
  } op_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state;
  logic [W-1:0] regs [8];
  logic [15:0]  ir;
  logic [W-1:0] addr_hold;

  // Instruction fields
  op_t          op;
  logic         imm_sel;
  logic [2:0]   rx;
  logic [2:0]   ry;
  logic [8:0]   imm9;

  // Datapath values
  logic [W-1:0] rx_val;
  logic [W-1:0] op2;
  logic [W:0]   add_sum;
  logic [W:0]   sub_sum;
  logic [W-1:0] and_res;
  logic [W-1:0] mvt_val;
  logic [W-1:0] br_off;
  logic         cond_true;

  assign op       = op_t'(ir[15:13]);
  assign imm_sel  = ir[12];
  assign rx       = ir[11:9];
  assign imm9     = ir[8:0];
  assign ry       = ir[2:0];

  assign rx_val   = regs[rx];
  assign op2      = imm_sel ? {{(W-9){1'b0}}, imm9} : regs[ry];
  assign add_sum  = {1'b0, rx_val} + {1'b0, op2};
  assign sub_sum  = {1'b0, rx_val} + {1'b0, ~op2} + {{W{1'b0}}, 1'b1};
  assign and_res  = rx_val & op2;
  assign mvt_val  = {imm9[7:0], {(W-8){1'b0}}};
  assign br_off   = {{(W-9){imm9[8]}}, imm9};

  assign pc       = regs[7];
  assign dbg_data = regs[dbg_sel];

  // Branch condition evaluation from the rX field against current flags
  always_comb begin
    cond_true = 1'b0;
    unique case (rx)
      3'b000: cond_true = 1'b1;
      3'b001: cond_true = flags[0];
      3'b010: cond_true = ~flags[0];
      3'b011: cond_true = ~flags[1];
      3'b100: cond_true = flags[1];
      3'b101: cond_true = ~flags[2];
      3'b110: cond_true = flags[2];
      3'b111: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  // Memory port: PC in FETCH, R[rY] in EXEC of ld/st, otherwise the last address
  always_comb begin
    mem_addr  = addr_hold;
    mem_wdata = rx_val;
    mem_we    = 1'b0;
    unique case (state)
      S_FETCH: mem_addr = regs[7];
      S_EXEC: begin
        if (op == OP_LD || op == OP_ST) begin
          mem_addr = regs[ry];
        end
        if (op == OP_ST) begin
          mem_we = 1'b1;
        end
      end
      default: mem_addr = addr_hold;
    endcase
  end

  // Control FSM, register file, flags and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 7; i++) begin
        regs[i[2:0]] <= '0;
      end
      regs[7]   <= RESET_PC;
      ir        <= '0;
      flags     <= '0;
      done      <= 1'b0;
      addr_hold <= RESET_PC;
      state     <= S_FETCH;
    end else begin
      done      <= 1'b0;
      addr_hold <= mem_addr;
      unique case (state)
        S_FETCH: begin
          if (run) begin
            regs[7] <= regs[7] + ONE;
            state   <= S_LOADIR;
          end
        end
        S_LOADIR: begin
          ir    <= mem_rdata[15:0];
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          done  <= 1'b1;
          // A write to R7 here lands after the FETCH increment, so it wins.
          unique case (op)
            OP_MV:  regs[rx] <= op2;
            OP_MVT: regs[rx] <= mvt_val;
            OP_ADD: begin
              regs[rx] <= add_sum[W-1:0];
              flags    <= {add_sum[W-1], add_sum[W], add_sum[W-1:0] == '0};
            end
            OP_SUB: begin
              regs[rx] <= sub_sum[W-1:0];
              flags    <= {sub_sum[W-1], sub_sum[W], sub_sum[W-1:0] == '0};
            end
            OP_AND: begin
              regs[rx] <= and_res;
              flags    <= {and_res[W-1], 1'b0, and_res == '0};
            end
            OP_LD: begin
              state <= S_LDWAIT;
              done  <= 1'b0;
            end
            OP_ST: begin
            end
            OP_B: begin
              if (cond_true) begin
                regs[7] <= regs[7] + br_off;
              end
            end
            default: begin
            end
          endcase
        end
        S_LDWAIT: begin
          regs[rx] <= mem_rdata;
          state    <= S_FETCH;
          done     <= 1'b1;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_param_processor.sv
// Testbench for param_processor: a W=16 core and a W=32 core with a
// non-zero reset PC, each attached to its own synchronous memory model.
module tb_param_processor;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] mem_rdata16;
  logic [15:0] mem_addr16;
  logic [15:0] mem_wdata16;
  logic        mem_we16;
  logic        done16;
  logic [15:0] pc16;
  logic [2:0]  flags16;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data16;

  logic        rst32;
  logic        run32;
  logic [31:0] mem_rdata32;
  logic [31:0] mem_addr32;
  logic [31:0] mem_wdata32;
  logic        mem_we32;
  logic        done32;
  logic [31:0] pc32;
  logic [2:0]  flags32;
  logic [2:0]  dbg_sel32;
  logic [31:0] dbg_data32;

  logic        bd_we;
  logic        bd_tgt;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;

  logic [15:0] mem16 [256];
  logic [31:0] mem32 [8];

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  logic [15:0] we_addr;
  logic [15:0] we_data;

  always #5 clk = ~clk;

  param_processor #(.W(16), .RESET_PC(16'd0)) u_dut (
    .clk(clk), .reset(reset), .run(run), .mem_rdata(mem_rdata16),
    .mem_addr(mem_addr16), .mem_wdata(mem_wdata16), .mem_we(mem_we16),
    .done(done16), .pc(pc16), .flags(flags16),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data16)
  );

  param_processor #(.W(32), .RESET_PC(32'd4)) u_dut32 (
    .clk(clk), .reset(rst32), .run(run32), .mem_rdata(mem_rdata32),
    .mem_addr(mem_addr32), .mem_wdata(mem_wdata32), .mem_we(mem_we32),
    .done(done32), .pc(pc32), .flags(flags32),
    .dbg_sel(dbg_sel32), .dbg_data(dbg_data32)
  );

  // Synchronous single-port memories with a backdoor load port
  always @(posedge clk) begin
    if (bd_we && !bd_tgt) mem16[bd_addr] <= bd_data[15:0];
    else if (mem_we16)    mem16[mem_addr16[7:0]] <= mem_wdata16;
    if (bd_we && bd_tgt)  mem32[bd_addr[2:0]] <= bd_data;
    else if (mem_we32)    mem32[mem_addr32[2:0]] <= mem_wdata32;
    mem_rdata16 <= mem16[mem_addr16[7:0]];
    mem_rdata32 <= mem32[mem_addr32[2:0]];
  end

  // Store observer
  always @(negedge clk) begin
    if (mem_we16) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= mem_addr16;
      we_data <= mem_wdata16;
    end
  end

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] instr;
    logic [2:0]  rsel;
    logic [15:0] rval;
    logic [15:0] pcv;
    logic [2:0]  fl;
  } vec_t;

  vec_t vt [26];
  vec_t sbq [$];
  vec_t e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d, input logic tgt);
    @(negedge clk);
    bd_we = 1'b1; bd_tgt = tgt; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  initial begin
    int cyc;
    int we0;
    // {addr, instr, reg to check, reg value, pc after, {N,C,Z}}
    vt[0]  = '{8'd0,  16'h1005, 3'd0, 16'h0005, 16'd1,  3'b000};
    vt[1]  = '{8'd1,  16'h11FF, 3'd0, 16'h01FF, 16'd2,  3'b000};
    vt[2]  = '{8'd2,  16'h5001, 3'd0, 16'h0200, 16'd3,  3'b000};
    vt[3]  = '{8'd3,  16'h30FF, 3'd0, 16'hFF00, 16'd4,  3'b000};
    vt[4]  = '{8'd4,  16'h50FF, 3'd0, 16'hFFFF, 16'd5,  3'b100};
    vt[5]  = '{8'd5,  16'h5001, 3'd0, 16'h0000, 16'd6,  3'b011};
    vt[6]  = '{8'd6,  16'h1203, 3'd1, 16'h0003, 16'd7,  3'b011};
    vt[7]  = '{8'd7,  16'h7203, 3'd1, 16'h0000, 16'd8,  3'b011};
    vt[8]  = '{8'd8,  16'hF201, 3'd1, 16'h0000, 16'd10, 3'b011};
    vt[9]  = '{8'd10, 16'h1620, 3'd3, 16'h0020, 16'd11, 3'b011};
    vt[10] = '{8'd11, 16'h3812, 3'd4, 16'h1200, 16'd12, 3'b011};
    vt[11] = '{8'd12, 16'h5834, 3'd4, 16'h1234, 16'd13, 3'b000};
    vt[12] = '{8'd13, 16'hA803, 3'd4, 16'h1234, 16'd14, 3'b000};
    vt[13] = '{8'd14, 16'h8A03, 3'd5, 16'h1234, 16'd15, 3'b000};
    vt[14] = '{8'd15, 16'h6A04, 3'd5, 16'h0000, 16'd16, 3'b011};
    vt[15] = '{8'd16, 16'hF405, 3'd5, 16'h0000, 16'd17, 3'b011};
    vt[16] = '{8'd17, 16'hD8F0, 3'd4, 16'h0030, 16'd18, 3'b000};
    vt[17] = '{8'd18, 16'h7C01, 3'd6, 16'hFFFF, 16'd19, 3'b100};
    vt[18] = '{8'd19, 16'hFC02, 3'd6, 16'hFFFF, 16'd22, 3'b100};
    vt[19] = '{8'd22, 16'h0407, 3'd2, 16'h0017, 16'd23, 3'b100};
    vt[20] = '{8'd23, 16'h1E1E, 3'd7, 16'h001E, 16'd30, 3'b100};
    vt[21] = '{8'd30, 16'hF7FA, 3'd7, 16'h0019, 16'd25, 3'b100};
    vt[22] = '{8'd25, 16'hFE05, 3'd7, 16'h001A, 16'd26, 3'b100};
    vt[23] = '{8'd26, 16'h11AB, 3'd0, 16'h01AB, 16'd27, 3'b100};
    vt[24] = '{8'd27, 16'h4000, 3'd0, 16'h0356, 16'd28, 3'b000};
    vt[25] = '{8'd28, 16'hE1FF, 3'd7, 16'h001C, 16'd28, 3'b000};

    reset = 1'b1; run = 1'b0; rst32 = 1'b1; run32 = 1'b0;
    bd_we = 1'b0; bd_tgt = 1'b0; bd_addr = '0; bd_data = '0;
    dbg_sel = '0; dbg_sel32 = '0;
    #2;

    // Reset state
    chk("rst_pc", pc16, 16'd0);
    chk("rst_flags", flags16, 3'b000);
    chk("rst_done", done16, 1'b0);
    chk("rst_we", mem_we16, 1'b0);
    chk("rst_pc32", pc32, 32'd4);
    for (int r = 0; r < 8; r++) begin
      dbg_sel = r[2:0];
      #1;
      chk($sformatf("rst_r%0d", r), dbg_data16, 16'd0);
    end

    // First instruction latency and asynchronous reset during FETCH
    poke(8'd0, 32'h1005, 1'b0);
    poke(8'd1, 32'hE1FF, 1'b0);
    @(negedge clk); reset = 1'b0; run = 1'b1; dbg_sel = 3'd0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("lat_done_early", done16, 1'b0);
    chk("lat_r0_early", dbg_data16, 16'd0);
    @(negedge clk);
    chk("lat_done", done16, 1'b1);
    chk("lat_pc", pc16, 16'd1);
    chk("lat_r0", dbg_data16, 16'd5);
    #1 reset = 1'b1;
    #1;
    chk("async_pc", pc16, 16'd0);
    chk("async_r0", dbg_data16, 16'd0);
    run = 1'b0;

    // Table-driven program with scoreboard
    for (int i = 0; i < 26; i++) begin
      poke(vt[i].addr, {16'h0, vt[i].instr}, 1'b0);
      sbq.push_back(vt[i]);
    end
    poke(8'd9,  32'h1277, 1'b0);
    poke(8'd20, 32'h1277, 1'b0);
    poke(8'd21, 32'h1277, 1'b0);
    poke(8'h20, 32'h0000, 1'b0);
    we0 = we_cnt;
    @(negedge clk); reset = 1'b0; run = 1'b1;
    cyc = 0;
    while (sbq.size() != 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done16) begin
        e = sbq.pop_front();
        dbg_sel = e.rsel;
        #1;
        chk($sformatf("vec@%0d_reg", e.addr), dbg_data16, e.rval);
        chk($sformatf("vec@%0d_pc", e.addr), pc16, e.pcv);
        chk($sformatf("vec@%0d_flags", e.addr), flags16, e.fl);
      end
    end
    chk("sb_drained", sbq.size(), 0);
    chk("st_count", we_cnt - we0, 1);
    chk("st_addr", we_addr, 16'h0020);
    chk("st_data", we_data, 16'h1234);
    chk("st_mem", mem16[8'h20], 16'h1234);

    // run dropped during EXEC of an add
    reset = 1'b1; run = 1'b0;
    poke(8'd0, 32'h5001, 1'b0);
    poke(8'd1, 32'h5001, 1'b0);
    poke(8'd2, 32'hE1FF, 1'b0);
    @(negedge clk); reset = 1'b0; run = 1'b1; dbg_sel = 3'd0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("halt_done", done16, 1'b1);
    chk("halt_r0", dbg_data16, 16'd1);
    chk("halt_pc", pc16, 16'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("halt_pc_c%0d", k), pc16, 16'd1);
      chk($sformatf("halt_nodone_c%0d", k), done16, 1'b0);
    end
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("resume_done", done16, 1'b1);
    chk("resume_r0", dbg_data16, 16'd2);
    chk("resume_pc", pc16, 16'd2);

    // Reset during LDWAIT, then a full ld for contrast
    reset = 1'b1; run = 1'b0;
    poke(8'd0, 32'h1640, 1'b0);
    poke(8'd1, 32'h8A03, 1'b0);
    poke(8'h40, 32'hBEEF, 1'b0);
    @(negedge clk); reset = 1'b0; run = 1'b1; dbg_sel = 3'd5;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("ldw_pc", pc16, 16'd2);
    chk("ldw_nodone", done16, 1'b0);
    reset = 1'b1;
    #1;
    chk("ldw_rst_r5", dbg_data16, 16'd0);
    chk("ldw_rst_pc", pc16, 16'd0);
    @(negedge clk); reset = 1'b0; run = 1'b0;
    repeat (3) @(negedge clk);
    chk("ldw_after_r5", dbg_data16, 16'd0);
    chk("ldw_after_pc", pc16, 16'd0);
    run = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("ld_done", done16, 1'b1);
    chk("ld_r5", dbg_data16, 16'hBEEF);
    chk("ld_pc", pc16, 16'd2);
    run = 1'b0;

    // W=32 core with RESET_PC=4: mvt r2,#0xAB; upper fetch bits ignored
    poke(8'd4, 32'hDEAD34AB, 1'b1);
    poke(8'd5, 32'h0000E1FF, 1'b1);
    @(negedge clk); rst32 = 1'b0; run32 = 1'b1; dbg_sel32 = 3'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("w32_done", done32, 1'b1);
    chk("w32_pc", pc32, 32'd5);
    chk("w32_r2", dbg_data32, 32'hAB000000);
    chk("w32_flags", flags32, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
